// File: rtl/cpu_if.sv
// cpu_if: RAM-side bus between the cpu (master) and its level-sensitive RAM (slave)
interface cpu_if #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 5
);
    logic                    ram_w;
    logic [ADDRESS_SIZE-1:0] ram_waddr;
    logic [WORD_SIZE-1:0]    ram_wdata;
    logic [ADDRESS_SIZE-1:0] ram_raddr;
    logic [WORD_SIZE-1:0]    ram_rdata;

    modport master (output ram_w, ram_waddr, ram_wdata, ram_raddr, input ram_rdata);
    modport slave  (input ram_w, ram_waddr, ram_wdata, ram_raddr, output ram_rdata);
endinterface

// File: rtl/cpu.sv
// cpu: tiny accumulator-pair CPU (LOAD pair / ADD pairs / STORE pair / HALT) over a combinational-read RAM
module cpu #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 5
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    cpu_if.master bus
);
    typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALT} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam logic [ADDRESS_SIZE-1:0] ONE_A = 1;

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0]    ir_q, ir_d;
    logic [WORD_SIZE-1:0]    r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic                    sel_q, sel_d;
    logic                    w_q, w_d;
    logic [ADDRESS_SIZE-1:0] waddr_q, waddr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [ADDRESS_SIZE-1:0] raddr;

    wire [2:0]              op      = ir_q[WORD_SIZE-1 -: 3];
    wire [2:0]              fetch_op = bus.ram_rdata[WORD_SIZE-1 -: 3];
    wire [ADDRESS_SIZE-1:0] a       = ir_q[ADDRESS_SIZE-1:0];
    wire [ADDRESS_SIZE-1:0] a1      = a + ONE_A;

    // State and datapath registers; en low freezes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            sel_q   <= 1'b0;
            w_q     <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (en) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            sel_q   <= sel_d;
            w_q     <= w_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: LOAD/STORE take two exec cycles, HALT parks forever, the rest return to fetch
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = EXEC1;
            EXEC1:   state_d = (op == OP_LOAD || op == OP_STORE) ? EXEC2 : (op == OP_HALT) ? HALT : FETCH;
            EXEC2:   state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // Read address and datapath updates; write strobe/address/data are set up one edge early so they are registered
    always_comb begin
        raddr   = pc_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        sel_d   = sel_q;
        w_d     = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            FETCH: begin
                ir_d = bus.ram_rdata;
                pc_d = pc_q + ONE_A;
                if (fetch_op == OP_STORE) begin
                    w_d     = 1'b1;
                    waddr_d = bus.ram_rdata[ADDRESS_SIZE-1:0];
                    wdata_d = r0_q;
                end
            end
            EXEC1: begin
                raddr = a;
                if (op == OP_LOAD) begin
                    r0_d = sel_q ? r0_q : bus.ram_rdata;
                    r2_d = sel_q ? bus.ram_rdata : r2_q;
                end
                if (op == OP_ADD) begin
                    r0_d = r0_q + r2_q;
                    r1_d = r1_q + r3_q;
                end
                if (op == OP_STORE) begin
                    w_d     = 1'b1;
                    waddr_d = a1;
                    wdata_d = r1_q;
                end
            end
            EXEC2: begin
                raddr = a1;
                if (op == OP_LOAD) begin
                    r1_d  = sel_q ? r1_q : bus.ram_rdata;
                    r3_d  = sel_q ? bus.ram_rdata : r3_q;
                    sel_d = ~sel_q;
                end
            end
            default: raddr = pc_q;
        endcase
    end

    assign bus.ram_w     = w_q & en;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_raddr = raddr;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: self-checking bench with a RAM model, write scoreboard and an ADD vector table
module tb_cpu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic [7:0] mem [32];

    cpu_if bus ();
    cpu dut (.clk(clk), .reset(reset), .en(en), .bus(bus));

    assign bus.ram_rdata = mem[bus.ram_raddr];

    always #5 clk = ~clk;

    typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] a0, a1, b0, b1, e0, e1; } vec_t;

    wr_t  sbq [$];
    vec_t vecs [5];
    int   checks = 0;
    int   failures = 0;
    int   run = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle: sample at negedge, perform RAM write, score it, track strobe width
    task automatic step();
        wr_t e;
        @(negedge clk);
        if (!reset) run = 0;
        else if (bus.ram_w) begin
            mem[bus.ram_waddr] = bus.ram_wdata;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %0d data %0d, no write expected", bus.ram_waddr, bus.ram_wdata);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", int'(bus.ram_waddr), int'(e.a));
                chk("wr_data", int'(bus.ram_wdata), int'(e.d));
            end
            run++;
        end else if (en && run != 0) begin
            chk("strobe_len", run, 2);
            run = 0;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
        en = 1'b1;
    endtask

    task automatic clr();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic base_prog();
        clr();
        mem[0] = 8'h0A;
        mem[1] = 8'h14;
        mem[2] = 8'h40;
        mem[3] = 8'h80;
        mem[4] = 8'hE0;
        mem[10] = 8'd3;
        mem[11] = 8'd7;
        mem[20] = 8'd4;
        mem[21] = 8'd6;
    endtask

    initial begin
        vecs[0] = '{8'd3,   8'd7,   8'd4,   8'd6,   8'd7,  8'd13};
        vecs[1] = '{8'd200, 8'd0,   8'd100, 8'd0,   8'd44, 8'd0};
        vecs[2] = '{8'd255, 8'd128, 8'd1,   8'd128, 8'd0,  8'd0};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,  8'd0};
        vecs[4] = '{8'd17,  8'd250, 8'd34,  8'd10,  8'd51, 8'd4};

        // base program, register load, halt and async reset
        base_prog();
        sbq.push_back('{5'd0, 8'd7});
        sbq.push_back('{5'd1, 8'd13});
        pulse();
        steps(6);
        chk("load_r0", int'(dut.r0_q), 3);
        chk("load_r1", int'(dut.r1_q), 7);
        chk("load_r2", int'(dut.r2_q), 4);
        chk("load_r3", int'(dut.r3_q), 6);
        chk("load_sel", int'(dut.sel_q), 0);
        steps(2);
        chk("add_r0", int'(dut.r0_q), 7);
        chk("add_r1", int'(dut.r1_q), 13);
        steps(5);
        chk("halt_pc", int'(dut.pc_q), 5);
        chk("base_drained", sbq.size(), 0);
        chk("base_mem0", int'(mem[0]), 7);
        chk("base_mem1", int'(mem[1]), 13);
        steps(3);
        chk("halt_pc_sticky", int'(dut.pc_q), 5);
        chk("halt_ram_w", int'(bus.ram_w), 0);
        #2 reset = 1'b0;
        #1;
        chk("rst_pc", int'(dut.pc_q), 0);
        chk("rst_ir", int'(dut.ir_q), 0);
        chk("rst_r0", int'(dut.r0_q), 0);
        chk("rst_r1", int'(dut.r1_q), 0);
        chk("rst_ram_w", int'(bus.ram_w), 0);
        chk("rst_waddr", int'(bus.ram_waddr), 0);
        chk("rst_wdata", int'(bus.ram_wdata), 0);
        chk("rst_raddr", int'(bus.ram_raddr), 0);

        // ADD vectors, including wrap-around
        foreach (vecs[k]) begin
            clr();
            mem[0] = 8'h0A;
            mem[1] = 8'h14;
            mem[2] = 8'h40;
            mem[3] = 8'h98;
            mem[4] = 8'hE0;
            mem[10] = vecs[k].a0;
            mem[11] = vecs[k].a1;
            mem[20] = vecs[k].b0;
            mem[21] = vecs[k].b1;
            sbq.push_back('{5'd24, vecs[k].e0});
            sbq.push_back('{5'd25, vecs[k].e1});
            pulse();
            steps(15);
            chk("vec_drained", sbq.size(), 0);
            chk("vec_mem24", int'(mem[24]), int'(vecs[k].e0));
            chk("vec_mem25", int'(mem[25]), int'(vecs[k].e1));
        end

        // STORE at A=31 wraps the second write to address 0
        clr();
        mem[0] = 8'h0A;
        mem[1] = 8'h9F;
        mem[2] = 8'hE0;
        mem[10] = 8'h55;
        mem[11] = 8'hAA;
        sbq.push_back('{5'd31, 8'h55});
        sbq.push_back('{5'd0, 8'hAA});
        pulse();
        steps(12);
        chk("wrap_drained", sbq.size(), 0);
        chk("wrap_mem31", int'(mem[31]), 8'h55);
        chk("wrap_mem0", int'(mem[0]), 8'hAA);

        // en freeze in the middle of the first LOAD
        base_prog();
        sbq.push_back('{5'd0, 8'd7});
        sbq.push_back('{5'd1, 8'd13});
        pulse();
        steps(2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_ram_w", int'(bus.ram_w), 0);
            chk("frz_raddr", int'(bus.ram_raddr), 11);
            chk("frz_pc", int'(dut.pc_q), 1);
            chk("frz_r0", int'(dut.r0_q), 3);
            chk("frz_r1", int'(dut.r1_q), 0);
        end
        en = 1'b1;
        steps(12);
        chk("frz_drained", sbq.size(), 0);
        chk("frz_mem0", int'(mem[0]), 7);
        chk("frz_mem1", int'(mem[1]), 13);

        // reset aborts STORE after EXEC1; first fetch waits for en
        base_prog();
        sbq.push_back('{5'd0, 8'd7});
        pulse();
        steps(9);
        #2 reset = 1'b0;
        #1;
        chk("abort_ram_w", int'(bus.ram_w), 0);
        chk("abort_pc", int'(dut.pc_q), 0);
        step();
        reset = 1'b1;
        en = 1'b0;
        steps(2);
        chk("en0_no_fetch", int'(dut.pc_q), 0);
        en = 1'b1;
        step();
        chk("first_fetch_pc", int'(dut.pc_q), 1);
        chk("first_fetch_ir", int'(dut.ir_q), 8'h07);
        chk("abort_drained", sbq.size(), 0);
        chk("abort_mem0", int'(mem[0]), 7);
        chk("abort_mem1", int'(mem[1]), 8'h14);

        // NOP stream: PC wraps 31 -> 0, two cycles per NOP
        clr();
        for (int i = 0; i < 32; i++) mem[i] = 8'h20;
        pulse();
        steps(64);
        chk("pc_wrap", int'(dut.pc_q), 0);
        steps(2);
        chk("pc_after_wrap", int'(dut.pc_q), 1);
        chk("nop_drained", sbq.size(), 0);
        chk("nop_r0", int'(dut.r0_q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
